// File: rtl/sieve_ctrl_pkg.sv
// Shared definitions for the sieve sequencer and its wrapper.
//   state_t    : sequencer states
//   sieve_n()  : sieve range N = 2**addr for a RAM of address width addr
//   COMPOSITE / CANDIDATE : meaning of a RAM bit (1 = n is known composite)
package sieve_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    SCAN_RD  = 3'd2,
    SCAN_CHK = 3'd3,
    EMIT     = 3'd4,
    MARK     = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam int ADDR_DEFAULT = 8;
  localparam int N_DEFAULT    = 2 ** ADDR_DEFAULT;

  localparam logic COMPOSITE = 1'b1;
  localparam logic CANDIDATE = 1'b0;

  function automatic int sieve_n(input int addr);
    return 2 ** addr;
  endfunction

endpackage

// File: rtl/sieve_ram.sv
// Single-port block RAM, read-before-write, registered read data.
//   clk  : clock
//   addr : read/write address
//   we   : write enable
//   din  : write data
//   dout : data at addr from the previous cycle (old contents on a write)
module sieve_ram #(
  parameter int ADDR = 8,
  parameter int DATA = 1
) (
  input  logic            clk,
  input  logic [ADDR-1:0] addr,
  input  logic            we,
  input  logic [DATA-1:0] din,
  output logic [DATA-1:0] dout
);

  logic [DATA-1:0] mem_r [2**ADDR];

  // Array write and registered read; dout sees the contents before this write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= din;
    end
    dout <= mem_r[addr];
  end

endmodule

// File: rtl/sieve_top.sv
// Sieve sequencer bundled with its 1-bit RAM.
//   clk, rst, start, busy, done, prime_valid, prime_ready, prime, prime_count :
//   as on sieve_ctrl; the RAM port is internal.
module sieve_top
  import sieve_ctrl_pkg::*;
#(
  parameter int ADDR = ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            prime_valid,
  input  logic            prime_ready,
  output logic [ADDR-1:0] prime,
  output logic [ADDR-1:0] prime_count
);

  logic [ADDR-1:0] mem_addr_s;
  logic            mem_wr_s;
  logic            mem_din_s;
  logic            mem_dout_s;

  sieve_ctrl #(.ADDR(ADDR)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .prime       (prime),
    .prime_count (prime_count),
    .mem_addr    (mem_addr_s),
    .mem_wr      (mem_wr_s),
    .mem_din     (mem_din_s),
    .mem_dout    (mem_dout_s)
  );

  sieve_ram #(.ADDR(ADDR), .DATA(1)) u_ram (
    .clk  (clk),
    .addr (mem_addr_s),
    .we   (mem_wr_s),
    .din  (mem_din_s),
    .dout (mem_dout_s)
  );

endmodule

// File: rtl/sieve_ctrl.sv
// Sieve of Eratosthenes sequencer over 0..N-1 (N = 2**ADDR). Owns every pin of
// a 1-bit-wide single-port RAM (bit n = 1 means n is composite), clears it,
// scans candidates from 2 upward, streams each prime and marks its multiples.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a run (honoured only in IDLE/DONE)
//   busy, done   : run in progress / run finished (held until next start)
//   prime_valid, prime_ready, prime : prime output handshake
//   prime_count  : primes accepted in the current run
//   mem_addr, mem_wr, mem_din, mem_dout : RAM port (dout valid one cycle late)
// All outputs are registered: the values for a state are loaded on the edge
// that enters it.
module sieve_ctrl
  import sieve_ctrl_pkg::*;
#(
  parameter int ADDR = ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            prime_valid,
  input  logic            prime_ready,
  output logic [ADDR-1:0] prime,
  output logic [ADDR-1:0] prime_count,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_wr,
  output logic            mem_din,
  input  logic            mem_dout
);

  localparam logic [ADDR:0]   N_V     = (ADDR+1)'(sieve_n(ADDR));
  localparam logic [ADDR:0]   LAST_V  = N_V - {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0]   ONE_V   = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0]   TWO_V   = {{(ADDR-1){1'b0}}, 2'b10};
  localparam logic [ADDR-1:0] CNT_ONE = {{(ADDR-1){1'b0}}, 1'b1};
  localparam logic [ADDR-1:0] ADDR_Z  = {ADDR{1'b0}};

  state_t          state_r, state_s;
  logic [ADDR:0]   i_r, i_s;
  logic [ADDR:0]   j_r, j_s;
  logic            busy_s, done_s, prime_valid_s, mem_wr_s, mem_din_s;
  logic [ADDR-1:0] prime_s, prime_count_s, mem_addr_s;

  logic [ADDR:0]   i_inc_s;
  logic [ADDR:0]   j_inc_s;
  logic [ADDR:0]   j_step_s;
  logic [ADDR+1:0] dbl_s;

  assign i_inc_s  = i_r + ONE_V;
  assign j_inc_s  = j_r + ONE_V;
  // j+i stays below 2N, so ADDR+1 bits never wrap.
  assign j_step_s = j_r + i_r;
  assign dbl_s    = {i_r, 1'b0};

  // Next-state and next-output logic; register values hold unless changed.
  always_comb begin
    state_s       = state_r;
    i_s           = i_r;
    j_s           = j_r;
    busy_s        = busy;
    done_s        = done;
    prime_valid_s = prime_valid;
    prime_s       = prime;
    prime_count_s = prime_count;
    mem_addr_s    = mem_addr;
    mem_wr_s      = mem_wr;
    mem_din_s     = mem_din;

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s       = CLEAR;
          j_s           = {(ADDR+1){1'b0}};
          busy_s        = 1'b1;
          done_s        = 1'b0;
          prime_count_s = ADDR_Z;
          mem_addr_s    = ADDR_Z;
          mem_wr_s      = 1'b1;
          mem_din_s     = CANDIDATE;
        end else begin
          mem_addr_s    = ADDR_Z;
          mem_wr_s      = 1'b0;
          mem_din_s     = 1'b0;
        end
      end

      CLEAR: begin
        if (j_r == LAST_V) begin
          // Present candidate 2 so SCAN_RD issues its read immediately.
          state_s    = SCAN_RD;
          i_s        = TWO_V;
          mem_addr_s = TWO_V[ADDR-1:0];
          mem_wr_s   = 1'b0;
        end else begin
          j_s        = j_inc_s;
          mem_addr_s = j_inc_s[ADDR-1:0];
        end
      end

      SCAN_RD: begin
        if (i_r == N_V) begin
          state_s    = DONE;
          busy_s     = 1'b0;
          done_s     = 1'b1;
          mem_addr_s = ADDR_Z;
          mem_din_s  = 1'b0;
        end else begin
          state_s    = SCAN_CHK;
        end
      end

      SCAN_CHK: begin
        if (mem_dout == COMPOSITE) begin
          state_s       = SCAN_RD;
          i_s           = i_inc_s;
          mem_addr_s    = i_inc_s[ADDR-1:0];
        end else begin
          state_s       = EMIT;
          prime_s       = i_r[ADDR-1:0];
          prime_valid_s = 1'b1;
        end
      end

      EMIT: begin
        if (prime_ready) begin
          prime_valid_s = 1'b0;
          prime_count_s = prime_count + CNT_ONE;
          if (dbl_s < {1'b0, N_V}) begin
            state_s    = MARK;
            j_s        = dbl_s[ADDR:0];
            mem_addr_s = dbl_s[ADDR-1:0];
            mem_wr_s   = 1'b1;
            mem_din_s  = COMPOSITE;
          end else begin
            state_s    = SCAN_RD;
            i_s        = i_inc_s;
            mem_addr_s = i_inc_s[ADDR-1:0];
          end
        end else begin
          state_s = EMIT;
        end
      end

      MARK: begin
        if (j_step_s >= N_V) begin
          state_s    = SCAN_RD;
          i_s        = i_inc_s;
          mem_addr_s = i_inc_s[ADDR-1:0];
          mem_wr_s   = 1'b0;
          mem_din_s  = CANDIDATE;
        end else begin
          j_s        = j_step_s;
          mem_addr_s = j_step_s[ADDR-1:0];
        end
      end

      default: begin
        state_s       = IDLE;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        prime_valid_s = 1'b0;
        mem_addr_s    = ADDR_Z;
        mem_wr_s      = 1'b0;
        mem_din_s     = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers with asynchronous reset to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      i_r         <= {(ADDR+1){1'b0}};
      j_r         <= {(ADDR+1){1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      prime_valid <= 1'b0;
      prime       <= ADDR_Z;
      prime_count <= ADDR_Z;
      mem_addr    <= ADDR_Z;
      mem_wr      <= 1'b0;
      mem_din     <= 1'b0;
    end else begin
      state_r     <= state_s;
      i_r         <= i_s;
      j_r         <= j_s;
      busy        <= busy_s;
      done        <= done_s;
      prime_valid <= prime_valid_s;
      prime       <= prime_s;
      prime_count <= prime_count_s;
      mem_addr    <= mem_addr_s;
      mem_wr      <= mem_wr_s;
      mem_din     <= mem_din_s;
    end
  end

endmodule

// File: tb/tb_sieve_ctrl.sv
module tb_sieve_ctrl;

  localparam int ADDR = 4;
  localparam int N    = 2 ** ADDR;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy, done, prime_valid, prime_ready;
  logic [ADDR-1:0] prime, prime_count, mem_addr;
  logic            mem_wr, mem_din, mem_dout;

  logic            ram_m [N];

  int checks = 0;
  int errors = 0;

  int exp_primes[$];
  int exp_base;
  int k, pidx, clear_idx, mark_exp, cur_p, emit_wait, first_valid_k, stall_n;
  bit prev_stall;
  logic [ADDR-1:0] prev_prime;

  always #5 clk = ~clk;

  sieve_ctrl #(.ADDR(ADDR)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .prime       (prime),
    .prime_count (prime_count),
    .mem_addr    (mem_addr),
    .mem_wr      (mem_wr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  // Behavioural single-port RAM: read-before-write, one cycle read latency.
  always @(posedge clk) begin
    if (mem_wr) ram_m[mem_addr] <= mem_din;
    mem_dout <= ram_m[mem_addr];
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_p(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic dirty_ram();
    for (int a = 0; a < N; a++) ram_m[a] = 1'($urandom_range(0, 1));
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic cycle();
    if (mem_wr) begin
      check("wr_in_emit", prime_valid, 0);
      if (clear_idx < N) begin
        check("clear_addr", mem_addr, clear_idx);
        check("clear_din", mem_din, 0);
        clear_idx++;
      end else begin
        check("mark_addr", mem_addr, mark_exp);
        check("mark_din", mem_din, 1);
        mark_exp += cur_p;
      end
    end
    if (prime_valid && first_valid_k == 0) first_valid_k = k;
    if (prev_stall) begin
      check("hold_valid", prime_valid, 1);
      check("hold_prime", prime, prev_prime);
    end
    if (prime_valid && prime_ready) begin
      check("count_before", prime_count, pidx);
      if (pidx < exp_primes.size()) check("prime", prime, exp_primes[pidx]);
      else check("extra_prime", pidx, exp_primes.size());
      cur_p    = int'(prime);
      mark_exp = 2 * cur_p;
      pidx++;
    end
    if (prime_valid && !prime_ready) emit_wait++;
    prev_stall = prime_valid && !prime_ready;
    prev_prime = prime;
    check("busy_run", busy, 1);
    @(posedge clk);
    #1;
    k++;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on first prime
  task automatic run(input int mode, input int busy_start_k, input bit abort_mark);
    k = 0; pidx = 0; clear_idx = 0; mark_exp = 0; cur_p = 0;
    emit_wait = 0; first_valid_k = 0; stall_n = 0; prev_stall = 1'b0;
    start = 1'b1;
    prime_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 1;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("count_cleared", prime_count, 0);
    while (!done && k < 1000) begin
      if (abort_mark && cur_p == 2 && mark_exp == 6) begin
        check("in_mark_wr", mem_wr, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs",
              {busy, done, prime_valid, prime, prime_count, mem_addr, mem_wr, mem_din}, 0);
        return;
      end
      start = (k == busy_start_k);
      case (mode)
        0:       prime_ready = 1'b1;
        1:       prime_ready = 1'($urandom_range(0, 1));
        default: begin
          if (prime_valid && pidx == 0 && stall_n < 5) begin
            prime_ready = 1'b0;
            stall_n++;
          end else begin
            prime_ready = 1'b1;
          end
        end
      endcase
      if (k == N + 1) check("clear_len", clear_idx, N);
      cycle();
    end
    start = 1'b0;
    prime_ready = 1'b0;
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("prime_total", pidx, exp_primes.size());
    check("prime_count", prime_count, exp_primes.size());
    check("clear_total", clear_idx, N);
    check("first_valid_cycle", first_valid_k, N + 3);
    check("done_cycle", k, exp_base + emit_wait);
    if (mode == 2) check("stall_cycles", emit_wait, 5);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("done_hold", done, 1);
      check("idle_wr", mem_wr, 0);
      check("idle_valid", prime_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    prime_ready = 1'b0;
    for (int n = 2; n < N; n++) if (is_p(n)) exp_primes.push_back(n);
    // Cycle index of the first DONE cycle when every prime is accepted at once.
    exp_base = N + 2;
    for (int n = 2; n < N; n++) exp_base += is_p(n) ? (3 + (N - 1) / n - 1) : 2;
    dirty_ram();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs",
          {busy, done, prime_valid, prime, prime_count, mem_addr, mem_wr, mem_din}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", {busy, done, mem_wr}, 0);

    run(0, 0, 1'b0);
    run(2, 0, 1'b0);
    run(1, 30, 1'b0);

    dirty_ram();
    run(0, 0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_hold_outs", {busy, done, prime_valid, mem_wr}, 0);
    rst = 1'b0;
    dirty_ram();
    @(posedge clk);
    #1;
    run(0, 0, 1'b0);
    run(1, 45, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
